st_seq: RTL and testbench

Multi-cycle control sequencer that produces the 3-bit state code `st` consumed by the address-register stage (`adr` select logic) directly downstream. It walks one instruction at a time through fetch, decode, address, read, execute and write phases. Memory phases stall on a ready handshake with a bounded timeout. `st` is a registered output, so the downstream stage always sees a glitch-free code that is stable for whole cycles.

---
 rtl/st_pkg.sv | 30 +++
 rtl/wait_timer.sv | 36 +++
 rtl/st_seq.sv | 119 +++++++++++
 tb/tb_st_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/st_pkg.sv
// Shared encodings for the control sequencer and the downstream address stage.
package st_pkg;

    localparam int unsigned ST_W = 3;
    localparam int unsigned OP_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE   = 3'b000,
        FETCH  = 3'b001,
        DECODE = 3'b010,
        ADDR   = 3'b011,
        READ   = 3'b100,
        EXEC   = 3'b101,
        WRITE  = 3'b110,
        DONE   = 3'b111
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_ALU   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_HALT  = 2'b11
    } op_t;

    // States that stall on the memory handshake.
    function automatic logic is_wait(input state_t s, input op_t o);
        return (s == FETCH) || (s == READ) || ((s == WRITE) && (o == OP_STORE));
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait counter; expired is registered and high while the count equals TIMEOUT.
module wait_timer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned WAIT_W  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt + WAIT_W'(1);
        end
    end

    // Flag is computed from the next count so it lines up with the stored count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            expired <= (cnt_nxt == WAIT_W'(TIMEOUT));
        end
    end

endmodule

// File: rtl/st_seq.sv
// Multi-cycle instruction sequencer producing the registered state code for the address stage.
module st_seq
    import st_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned WAIT_W  = 4,
    parameter int unsigned ICNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic              mem_rdy,
    input  logic              abort,
    output logic [ST_W-1:0]   st,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ICNT_W-1:0] icnt
);

    state_t            state;
    state_t            nxt_state;
    op_t               op_q;
    op_t               nxt_op;
    logic              nxt_err;
    logic [ICNT_W-1:0] nxt_icnt;
    logic              waiting;
    logic              expired;
    logic              tmr_clr;
    logic              tmr_en;

    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .WAIT_W  (WAIT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (expired)
    );

    always_comb begin
        nxt_state = state;
        nxt_op    = op_q;
        nxt_err   = err;
        nxt_icnt  = icnt;
        waiting   = is_wait(state, op_q);

        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt_state = FETCH;
                    nxt_err   = 1'b0;
                    nxt_icnt  = '0;
                    nxt_op    = OP_ALU;
                end
            end
            FETCH:  if (mem_rdy) nxt_state = DECODE;
            DECODE: begin
                nxt_op = op_t'(op);
                unique case (op_t'(op))
                    OP_ALU:             nxt_state = EXEC;
                    OP_LOAD, OP_STORE:  nxt_state = ADDR;
                    OP_HALT:            nxt_state = DONE;
                endcase
            end
            ADDR:   nxt_state = (op_q == OP_LOAD) ? READ : WRITE;
            READ:   if (mem_rdy) nxt_state = EXEC;
            EXEC:   nxt_state = WRITE;
            WRITE: begin
                if ((op_q != OP_STORE) || mem_rdy) begin
                    nxt_state = FETCH;
                    nxt_icnt  = icnt + ICNT_W'(1);
                end
            end
            DONE:   nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        // Timeout only when the handshake did not land in the expiring cycle.
        if (waiting && !mem_rdy && expired) begin
            nxt_state = DONE;
            nxt_err   = 1'b1;
        end

        // Abort wins over everything and discards any completion side effects.
        if ((state != IDLE) && (state != DONE) && abort) begin
            nxt_state = DONE;
            nxt_err   = err;
            nxt_icnt  = icnt;
        end

        tmr_clr = (nxt_state != state);
        tmr_en  = waiting && !mem_rdy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_ALU;
            err   <= 1'b0;
            icnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt_state;
            op_q  <= nxt_op;
            err   <= nxt_err;
            icnt  <= nxt_icnt;
            busy  <= (nxt_state != IDLE);
            done  <= (nxt_state == DONE);
        end
    end

    assign st = state;

endmodule

// File: tb/tb_st_seq.sv
// Bench for st_seq: directed scenarios plus random instruction streams against a phase-level model.
module tb_st_seq;

    localparam int unsigned TO = 15;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic          mem_rdy;
    logic          abort;
    logic [2:0]    st;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] icnt;

    int   total = 0;
    int   bad   = 0;
    logic m_err;
    int   m_icnt;
    bit   ended;

    always #5 clk = ~clk;

    st_seq #(.TIMEOUT(TO), .WAIT_W(4), .ICNT_W(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .mem_rdy (mem_rdy),
        .abort   (abort),
        .st      (st),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .icnt    (icnt)
    );

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Mostly short stalls, sometimes exactly at the limit, sometimes one past it.
    function automatic int pick();
        int r = $urandom_range(0, 39);
        if (r < 36) return $urandom_range(0, 3);
        if (r < 38) return TO;
        return TO + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: check the current cycle's outputs, then drive this cycle's inputs.
    task automatic cyc(input int exp, input logic rdy, input logic ab,
                       input logic [1:0] opv, input logic stv);
        @(negedge clk);
        chk("st",   st,   exp);
        chk("busy", busy, 32'(exp != 0));
        chk("done", done, 32'(exp == 7));
        chk("err",  err,  m_err);
        chk("icnt", icnt, 32'(m_icnt % (1 << IW)));
        mem_rdy = rdy;
        abort   = ab;
        op      = opv;
        start   = stv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, rb(), rb(), 2'($urandom), 1'b0);
    endtask

    task automatic begin_prog();
        cyc(0, rb(), rb(), 2'($urandom), 1'b1);
        m_err  = 1'b0;
        m_icnt = 0;
    endtask

    task automatic end_prog(input logic hold);
        cyc(7, rb(), rb(), 2'($urandom), hold);
    endtask

    // One phase of an instruction; waiting phases stall for 'stall' cycles.
    task automatic phase(input int code, input bit w, input int stall, input bit ab,
                         input logic [1:0] opv, output bit fin);
        fin = 1'b0;
        if (ab) begin
            if (w) for (int i = 0; i < stall && i < int'(TO); i++) cyc(code, 1'b0, 1'b0, opv, rb());
            cyc(code, 1'b1, 1'b1, opv, rb());
            fin = 1'b1;
        end else if (w && stall > int'(TO)) begin
            for (int i = 0; i <= int'(TO); i++) cyc(code, 1'b0, 1'b0, opv, rb());
            m_err = 1'b1;
            fin   = 1'b1;
        end else if (w) begin
            for (int i = 0; i < stall; i++) cyc(code, 1'b0, 1'b0, opv, rb());
            cyc(code, 1'b1, 1'b0, opv, rb());
        end else begin
            cyc(code, rb(), 1'b0, opv, rb());
        end
    endtask

    task automatic run_instr(input logic [1:0] o, input int fs, input int ms,
                             input int ab_ph, output bit fin);
        int q[$];
        bit wq[$];
        case (o)
            2'd0:    begin q = '{1, 2, 5, 6};       wq = '{1, 0, 0, 0};       end
            2'd1:    begin q = '{1, 2, 3, 4, 5, 6}; wq = '{1, 0, 0, 1, 0, 0}; end
            2'd2:    begin q = '{1, 2, 3, 6};       wq = '{1, 0, 0, 1};       end
            default: begin q = '{1, 2};             wq = '{1, 0};             end
        endcase
        fin = 1'b0;
        foreach (q[i]) begin
            phase(q[i], wq[i], (i == 0) ? fs : ms, (i == ab_ph),
                  (q[i] == 2) ? o : 2'($urandom), fin);
            if (fin) return;
        end
        if (o == 2'd3) fin = 1'b1;
        else m_icnt++;
    endtask

    task automatic run_prog(input int n, input logic hold);
        bit fin = 1'b0;
        begin_prog();
        for (int k = 0; k < n && !fin; k++) begin
            run_instr(2'($urandom_range(0, 2)), pick(), pick(),
                      ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 5)) : -1, fin);
        end
        if (!fin) run_instr(2'd3, pick(), 0, ($urandom_range(0, 15) == 0) ? 1 : -1, fin);
        end_prog(hold);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_rdy = 1'b0; abort = 1'b0; op = 2'd0;
        m_err = 1'b0; m_icnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(3);

        // ALU x3 then HALT with no stalls.
        begin_prog();
        for (int i = 0; i < 3; i++) run_instr(2'd0, 0, 0, -1, ended);
        run_instr(2'd3, 0, 0, -1, ended);
        end_prog(1'b0);
        idle(1);

        // LOAD stalled 5 cycles in READ.
        begin_prog();
        run_instr(2'd1, 0, 5, -1, ended);
        run_instr(2'd3, 0, 0, -1, ended);
        end_prog(1'b0);

        // STORE timeout in WRITE, err sticky until the next start.
        begin_prog();
        run_instr(2'd2, 0, TO + 1, -1, ended);
        end_prog(1'b0);
        idle(2);
        begin_prog();
        run_instr(2'd1, TO, TO, -1, ended);
        run_instr(2'd3, 0, 0, -1, ended);
        end_prog(1'b1);

        // Abort together with mem_rdy in FETCH, then abort on a completing STORE write.
        begin_prog();
        run_instr(2'd0, 0, 0, -1, ended);
        run_instr(2'd0, 0, 0, 0, ended);
        end_prog(1'b0);
        begin_prog();
        run_instr(2'd2, 0, 0, 3, ended);
        end_prog(1'b0);

        // icnt wraps: five ALU instructions.
        begin_prog();
        for (int i = 0; i < 5; i++) run_instr(2'd0, 0, 0, -1, ended);
        run_instr(2'd3, 0, 0, -1, ended);
        end_prog(1'b0);

        // Asynchronous reset in the middle of a stalled READ.
        begin_prog();
        run_instr(2'd0, 0, 0, -1, ended);
        cyc(1, 1'b1, 1'b0, 2'd0, 1'b0);
        cyc(2, 1'b0, 1'b0, 2'd1, 1'b0);
        cyc(3, 1'b0, 1'b0, 2'd0, 1'b0);
        cyc(4, 1'b0, 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_st",   st,   0);
        chk("rst_icnt", icnt, 0);
        chk("rst_err",  err,  0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        m_icnt = 0;
        m_err  = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc(0, rb(), rb(), 2'($urandom), 1'b0);

        // Random instruction streams.
        for (int p = 0; p < 40; p++) begin
            logic h = rb();
            run_prog($urandom_range(1, 8), h);
            if (!h) idle($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
